axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
// - Shares one AXI3-style write slave (AW/W/B channels, 4-bit ID/len, 32-bit addr/data) among NUM_M write masters.
// - Serialises transactions: one master owns the path from its AW acceptance until its B handshake.
// - Sits between the master-side axi_if instances and the single slave axi_if in the bench/SoC.
// PARAMETERS
// - NUM_M   2   number of masters (2..4)
// - ID_W    4   awid/wid/bid width
// - ADDR_W  32  awaddr width
// - DATA_W  32  wdata width; wstrb is DATA_W/8
// - LEN_W   4   awlen width
// PORTS  (m_* buses are packed NUM_M-wide, master k at slice k)
// - clk                                     in   1         clock, all logic on rising edge
// - reset                                   in   1         asynchronous, active-high reset
// - m_awvalid / m_awready                   in / out  NUM_M  per-master AW handshake
// - m_awid,awlen,awsize,awaddr,awburst      in   NUM_M*{ID_W,LEN_W,3,ADDR_W,2}   AW payload
// - m_wvalid / m_wready                     in / out  NUM_M  per-master W handshake
// - m_wid,wdata,wstrb,wlast                 in   NUM_M*{ID_W,DATA_W,DATA_W/8,1}  W payload
// - m_bvalid / m_bready                     out / in  NUM_M  per-master B handshake
// - m_bid,bresp                             out  {ID_W,2}  B payload, broadcast to all masters
// - s_awvalid/awid/awlen/awsize/awaddr/awburst  out  AW to slave;  s_awready  in
// - s_wvalid/wid/wdata/wstrb/wlast          out  W to slave;   s_wready  in
// - s_bvalid/bid/bresp  in   B from slave;  s_bready  out
// - grant                                   out  $clog2(NUM_M)  index of owning master
// - busy                                    out  1         high in any state except IDLE
// - err_beat                                out  1         1-cycle pulse on W beat-count mismatch
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, busy=0, err_beat=0, all *valid/*ready outputs 0.
// - FSM IDLE->ADDR->DATA->RESP->IDLE. Routing is combinational, from registered grant only.
// - IDLE: if any m_awvalid, round-robin pick: first requester at or after rr_ptr (wrapping). Register grant -> ADDR. No AW mux in IDLE (1-cycle arbitration latency).
// - ADDR: s_aw* = m_aw*[grant], m_awready[grant] = s_awready. On s_awvalid&s_awready: latch awlen, beat_cnt=0 -> DATA.
// - DATA: s_w* = m_w*[grant], m_wready[grant] = s_wready. Each W handshake beat_cnt++. Handshake with s_wlast -> RESP.
// - RESP: m_bvalid[grant] = s_bvalid, s_bready = m_bready[grant]. On handshake: rr_ptr = (grant+1) mod NUM_M -> IDLE.
// - Non-granted masters, and any channel outside its state: ready/bvalid driven 0. s_*valid is 0 outside its state.
// - W beats presented before AW are held off (m_wready=0) until DATA.
// - Simultaneous requests: round-robin only, no fixed priority. A lone requester is re-granted back-to-back.
// - Minimum transaction: 1 (arb) + 1 (AW) + awlen+1 (W) + 1 (B) cycles with slave always ready.
// - Reset mid-operation: immediate return to IDLE, all handshakes drop; in-flight burst abandoned.
// - beat_cnt is LEN_W+1 bits wide and saturates at 2^LEN_W; no wrap.
// CONFIGURATION
// - AXI_WARB_BEAT_CHECK_EN defined:
//   - s_wlast = (beat_cnt == latched awlen), regardless of master wlast.
//   - err_beat pulses for one cycle on any W handshake where m_wlast[grant] != (beat_cnt == awlen).
//   - The burst always ends after awlen+1 beats.
// - Not defined: s_wlast = m_wlast[grant]; err_beat tied 0; beat_cnt logic omitted.
// STRUCTURE
// - Package axi_warb_pkg: typedef enum {IDLE,ADDR,DATA,RESP} warb_state_t; AXI burst consts FIXED/INCR/WRAP; resp consts OKAY/EXOKAY/SLVERR/DECERR.
// - Sub-module rr_arbiter #(N): inputs req[N], ptr; output gnt_idx, gnt_valid. Purely combinational priority rotate.
// TESTING
// - Single master 0, awlen=3, awaddr=0x1000, slave always ready:
//   grant=0, 4 W beats, B OKAY at m_bvalid[0]; busy high for 7 cycles.
// - Masters 0 and 1 both request in same cycle, awlen=0:
//   grant order 0 then 1, then 0 again on repeat; m_awready[1] stays 0 during master-0 ownership.
// - Slave backpressure: s_awready low 3 cycles, s_wready toggling, s_bvalid after 5 cycles:
//   payloads held stable, no beat lost, FSM reaches IDLE once per transaction.
// - Master 1 drives W before AW:
//   m_wready[1]=0 until AW handshake; data arrives at slave in order, wid=awid=0x5.
// - Assert reset in DATA after beat 2 of awlen=7:
//   same cycle all valids/readies 0, busy=0, rr_ptr=0; next request arbitrates fresh.
// - With AXI_WARB_BEAT_CHECK_EN, awlen=3 and master wlast on beat 2:
//   err_beat pulses on that beat, s_wlast on beat 4, B routed normally.

Source files
------------

// File: rtl/axi_warb_pkg.sv
// Shared state encoding, AXI burst/response codes and index helper for the write arbiter.
package axi_warb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } warb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Modulo-n increment without a divider.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; no state.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the closest requester to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr) + off) % N);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Serialises NUM_M AXI write masters onto one slave; one owner from AW accept to B handshake.
// 1-cycle arbitration, then combinational routing from registered grant; beat check under AXI_WARB_BEAT_CHECK_EN.
module axi_wr_arbiter
  import axi_warb_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_M-1:0]                    m_awvalid,
  output logic [NUM_M-1:0]                    m_awready,
  input  logic [NUM_M-1:0][ID_W-1:0]          m_awid,
  input  logic [NUM_M-1:0][LEN_W-1:0]         m_awlen,
  input  logic [NUM_M-1:0][2:0]               m_awsize,
  input  logic [NUM_M-1:0][ADDR_W-1:0]        m_awaddr,
  input  logic [NUM_M-1:0][1:0]               m_awburst,
  input  logic [NUM_M-1:0]                    m_wvalid,
  output logic [NUM_M-1:0]                    m_wready,
  input  logic [NUM_M-1:0][ID_W-1:0]          m_wid,
  input  logic [NUM_M-1:0][DATA_W-1:0]        m_wdata,
  input  logic [NUM_M-1:0][DATA_W/8-1:0]      m_wstrb,
  input  logic [NUM_M-1:0]                    m_wlast,
  output logic [NUM_M-1:0]                    m_bvalid,
  input  logic [NUM_M-1:0]                    m_bready,
  output logic [ID_W-1:0]                     m_bid,
  output logic [1:0]                          m_bresp,
  output logic                                s_awvalid,
  input  logic                                s_awready,
  output logic [ID_W-1:0]                     s_awid,
  output logic [LEN_W-1:0]                    s_awlen,
  output logic [2:0]                          s_awsize,
  output logic [ADDR_W-1:0]                   s_awaddr,
  output logic [1:0]                          s_awburst,
  output logic                                s_wvalid,
  input  logic                                s_wready,
  output logic [ID_W-1:0]                     s_wid,
  output logic [DATA_W-1:0]                   s_wdata,
  output logic [DATA_W/8-1:0]                 s_wstrb,
  output logic                                s_wlast,
  input  logic                                s_bvalid,
  output logic                                s_bready,
  input  logic [ID_W-1:0]                     s_bid,
  input  logic [1:0]                          s_bresp,
  output logic [$clog2(NUM_M)-1:0]            grant,
  output logic                                busy,
  output logic                                err_beat
);

  localparam int IDX_W = $clog2(NUM_M);

  warb_state_t      state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic             aw_hs, w_hs, b_hs;
  logic             w_last;

  rr_arbiter #(.N(NUM_M)) u_rr (
    .req       (m_awvalid),
    .ptr       (rr_ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_vld)
  );

  assign aw_hs = (state_q == ADDR) && m_awvalid[grant_q] && s_awready;
  assign w_hs  = (state_q == DATA) && m_wvalid[grant_q]  && s_wready;
  assign b_hs  = (state_q == RESP) && s_bvalid           && m_bready[grant_q];

  // Payloads follow the registered grant; only the valids/readies are state-gated.
  assign s_awid    = m_awid[grant_q];
  assign s_awlen   = m_awlen[grant_q];
  assign s_awsize  = m_awsize[grant_q];
  assign s_awaddr  = m_awaddr[grant_q];
  assign s_awburst = m_awburst[grant_q];
  assign s_wid     = m_wid[grant_q];
  assign s_wdata   = m_wdata[grant_q];
  assign s_wstrb   = m_wstrb[grant_q];
  assign s_wlast   = w_last;
  assign m_bid     = s_bid;
  assign m_bresp   = s_bresp;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

`ifdef AXI_WARB_BEAT_CHECK_EN
  localparam logic [LEN_W:0] BEAT_MAX = (LEN_W + 1)'(1) << LEN_W;

  logic [LEN_W-1:0] awlen_q, awlen_d;
  logic [LEN_W:0]   beat_cnt_q, beat_cnt_d;
  logic             beat_last;

  // The burst length comes from the accepted AW, not from the master's wlast.
  assign beat_last = (beat_cnt_q == {1'b0, awlen_q});
  assign w_last    = beat_last;
  assign err_beat  = w_hs && (m_wlast[grant_q] != beat_last);

  always_comb begin
    awlen_d    = awlen_q;
    beat_cnt_d = beat_cnt_q;
    if (aw_hs) begin
      awlen_d    = m_awlen[grant_q];
      beat_cnt_d = '0;
    end else if (w_hs && (beat_cnt_q != BEAT_MAX)) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      awlen_q    <= awlen_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  assign w_last   = m_wlast[grant_q];
  assign err_beat = 1'b0;
`endif

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    unique case (state_q)
      ADDR: begin
        s_awvalid          = m_awvalid[grant_q];
        m_awready[grant_q] = s_awready;
      end
      DATA: begin
        s_wvalid          = m_wvalid[grant_q];
        m_wready[grant_q] = s_wready;
      end
      RESP: begin
        m_bvalid[grant_q] = s_bvalid;
        s_bready          = m_bready[grant_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          state_d = ADDR;
        end
      end
      ADDR: if (aw_hs) state_d = DATA;
      DATA: if (w_hs && w_last) state_d = RESP;
      RESP: begin
        if (b_hs) begin
          rr_ptr_d = IDX_W'(wrap_inc(int'(grant_q), NUM_M));
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Cycle-stepped bench: master/slave agents plus a transaction-level ownership model for axi_wr_arbiter.
module tb_axi_wr_arbiter;

  localparam int NM = 3;
`ifdef AXI_WARB_BEAT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NM-1:0]        m_awvalid, m_awready;
  logic [NM-1:0][3:0]   m_awid, m_awlen;
  logic [NM-1:0][2:0]   m_awsize;
  logic [NM-1:0][31:0]  m_awaddr;
  logic [NM-1:0][1:0]   m_awburst;
  logic [NM-1:0]        m_wvalid, m_wready;
  logic [NM-1:0][3:0]   m_wid;
  logic [NM-1:0][31:0]  m_wdata;
  logic [NM-1:0][3:0]   m_wstrb;
  logic [NM-1:0]        m_wlast;
  logic [NM-1:0]        m_bvalid, m_bready;
  logic [3:0]           m_bid;
  logic [1:0]           m_bresp;
  logic                 s_awvalid, s_awready;
  logic [3:0]           s_awid, s_awlen;
  logic [2:0]           s_awsize;
  logic [31:0]          s_awaddr;
  logic [1:0]           s_awburst;
  logic                 s_wvalid, s_wready;
  logic [3:0]           s_wid;
  logic [31:0]          s_wdata;
  logic [3:0]           s_wstrb;
  logic                 s_wlast;
  logic                 s_bvalid, s_bready;
  logic [3:0]           s_bid;
  logic [1:0]           s_bresp;
  logic [1:0]           grant;
  logic                 busy, err_beat;

  axi_wr_arbiter #(.NUM_M(NM)) dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awaddr(m_awaddr), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awaddr(s_awaddr), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .grant(grant), .busy(busy), .err_beat(err_beat)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [3:0]  len;
    logic [31:0] addr;
    logic [31:0] base;
    logic [4:0]  bad;   // beat index carrying a wrong wlast; 31 = well-behaved master
  } txn_t;

  txn_t mq[NM][$];
  bit   aw_sent[NM];
  int   wbeat[NM];
  bit   w_early[NM];

  bit          rnd, w_toggle, b_pend;
  int          aw_stall, b_delay, b_cnt;
  logic [3:0]  b_id, cur_awid;
  logic [1:0]  b_rsp;
  logic [31:0] slog[$];
  logic [3:0]  slog_id[$];
  int          last_pos;

  int own, rr, mbeats;
  bit maw, mw;

  int n_chk, n_err, cyc, done_cnt, idle_ret, busy_cnt, err_cnt;
  int early_held, early_bad;
  bit busy_prev;
  int gnt_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_dat(input txn_t t, input int i);
    return t.base + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic txn_t mk(input logic [3:0] id, input logic [3:0] len,
                              input logic [31:0] addr, input logic [4:0] bad);
    txn_t t;
    t.id = id; t.len = len; t.addr = addr; t.base = $urandom; t.bad = bad;
    return t;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NM; k++) s += mq[k].size();
    return s;
  endfunction

  task automatic clear_state();
    for (int k = 0; k < NM; k++) begin
      mq[k].delete(); aw_sent[k] = 0; wbeat[k] = 0; w_early[k] = 0;
    end
    own = -1; rr = 0; mbeats = 0; maw = 0; mw = 0;
    b_pend = 0; b_cnt = 0; aw_stall = 0; w_toggle = 0; rnd = 0; b_delay = 1;
    b_id = '0; b_rsp = '0; cur_awid = '0; busy_prev = 0;
  endtask

  task automatic drive();
    txn_t t;
    for (int k = 0; k < NM; k++) begin
      m_awvalid[k] = 1'b0; m_wvalid[k] = 1'b0; m_wlast[k] = 1'b0;
      m_awid[k] = '0; m_awlen[k] = '0; m_awaddr[k] = '0; m_wid[k] = '0; m_wdata[k] = '0;
      m_awsize[k] = 3'd2; m_awburst[k] = 2'b01; m_wstrb[k] = 4'hf;
      m_bready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mq[k].size() > 0) begin
        t = mq[k][0];
        m_awvalid[k] = !aw_sent[k];
        m_awid[k] = t.id; m_awlen[k] = t.len; m_awaddr[k] = t.addr;
        m_wvalid[k] = (aw_sent[k] || w_early[k]) && (wbeat[k] <= int'(t.len));
        m_wid[k] = t.id;
        m_wdata[k] = beat_dat(t, wbeat[k]);
        m_wlast[k] = (t.bad != 5'd31) ? (wbeat[k] == int'(t.bad)) : (wbeat[k] == int'(t.len));
      end
    end
    s_awready = rnd ? ($urandom_range(0, 3) != 0) : (aw_stall == 0);
    s_wready  = rnd ? 1'($urandom_range(0, 1)) : (w_toggle ? cyc[0] : 1'b1);
    s_bvalid  = b_pend && (b_cnt == 0);
    s_bid     = b_id;
    s_bresp   = b_rsp;
  endtask

  task automatic check_cycle();
    logic [NM-1:0] e_awr, e_wr, e_bv;
    logic e_sav, e_swv, e_sbr, e_err, e_last;
    txn_t t;
    e_awr = '0; e_wr = '0; e_bv = '0;
    e_sav = 0; e_swv = 0; e_sbr = 0; e_err = 0; e_last = 0; t = '0;
    chk("busy", busy, own >= 0);
    chk("bid_bcast", m_bid, s_bid);
    chk("bresp_bcast", m_bresp, s_bresp);
    if (own >= 0) begin
      if (mq[own].size() > 0) t = mq[own][0];
      chk("grant", grant, own);
      if (!maw) begin
        e_sav = m_awvalid[own];
        e_awr[own] = s_awready;
        if (e_sav) begin
          chk("s_awaddr", s_awaddr, t.addr);
          chk("s_awid", s_awid, t.id);
          chk("s_awlen", s_awlen, t.len);
        end
      end else if (!mw) begin
        e_swv = m_wvalid[own];
        e_wr[own] = s_wready;
        e_last = CHK_EN ? (mbeats == int'(t.len)) : m_wlast[own];
        if (e_swv) begin
          chk("s_wdata", s_wdata, beat_dat(t, mbeats));
          chk("s_wid", s_wid, t.id);
          chk("s_wlast", s_wlast, e_last);
        end
        e_err = CHK_EN && e_swv && s_wready && (m_wlast[own] != (mbeats == int'(t.len)));
      end else begin
        e_bv[own] = s_bvalid;
        e_sbr = m_bready[own];
      end
    end
    chk("m_awready", m_awready, e_awr);
    chk("m_wready", m_wready, e_wr);
    chk("m_bvalid", m_bvalid, e_bv);
    chk("s_awvalid", s_awvalid, e_sav);
    chk("s_wvalid", s_wvalid, e_swv);
    chk("s_bready", s_bready, e_sbr);
    chk("err_beat", err_beat, e_err);
  endtask

  task automatic update();
    txn_t t;
    bit last;
    t = '0;
    // Ownership model: round-robin pick, AW, len+1 (or wlast-terminated) beats, B.
    if (own < 0) begin
      if (|m_awvalid) begin
        for (int i = NM - 1; i >= 0; i--) if (m_awvalid[(rr + i) % NM]) own = (rr + i) % NM;
        maw = 0; mw = 0; mbeats = 0;
      end
    end else begin
      if (mq[own].size() > 0) t = mq[own][0];
      if (!maw) begin
        if (m_awvalid[own] && s_awready) maw = 1;
      end else if (!mw) begin
        if (m_wvalid[own] && s_wready) begin
          last = CHK_EN ? (mbeats == int'(t.len)) : m_wlast[own];
          mbeats++;
          if (last) mw = 1;
        end
      end else if (s_bvalid && m_bready[own]) begin
        rr = (own + 1) % NM; own = -1; idle_ret++;
      end
    end
    if (m_wvalid[1] && !aw_sent[1] && !m_wready[1]) early_held++;
    if (m_wready[1] && !aw_sent[1]) early_bad++;
    for (int k = 0; k < NM; k++) begin
      if (m_awvalid[k] && m_awready[k]) aw_sent[k] = 1;
      if (m_wvalid[k] && m_wready[k]) wbeat[k]++;
      if (m_bvalid[k] && m_bready[k]) begin
        chk("m_bresp", m_bresp, b_rsp);
        chk("m_bid", m_bid, b_id);
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        aw_sent[k] = 0; wbeat[k] = 0; done_cnt++;
      end
    end
    if (s_awvalid && aw_stall > 0) aw_stall--;
    if (s_awvalid && s_awready) cur_awid = s_awid;
    if (s_bvalid && s_bready) b_pend = 0;
    else if (b_pend && b_cnt > 0) b_cnt--;
    if (s_wvalid && s_wready) begin
      if (s_wlast) begin
        last_pos = slog.size();
        b_pend = 1; b_cnt = b_delay; b_id = cur_awid;
        b_rsp = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
      end
      slog.push_back(s_wdata);
      slog_id.push_back(s_wid);
    end
  endtask

  task automatic tick();
    drive();
    #1;
    check_cycle();
    if (busy && !busy_prev) gnt_log.push_back(int'(grant));
    busy_prev = busy;
    if (busy) busy_cnt++;
    if (err_beat) err_cnt++;
    update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pending() > 0 || own >= 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", pending() + int'(own >= 0), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_awready"}, m_awready, '0);
    chk({tag, "_wready"}, m_wready, '0);
    chk({tag, "_bvalid"}, m_bvalid, '0);
    chk({tag, "_svalid"}, {s_awvalid, s_wvalid, s_bready}, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant"}, grant, '0);
    chk({tag, "_err"}, err_beat, 1'b0);
  endtask

  initial begin
    txn_t t;
    int   exp_g[4];
    int   d0, i0, reached;
    n_chk = 0; n_err = 0; cyc = 0; done_cnt = 0; idle_ret = 0;
    clear_state();
    reset = 1'b1;
    drive();
    @(negedge clk);
    @(negedge clk);
    check_quiet("rst");
    reset = 1'b0;

    // Simultaneous requests from masters 0 and 1, two rounds each.
    exp_g = '{0, 1, 0, 1};
    for (int r = 0; r < 2; r++) begin
      mq[0].push_back(mk(4'h1, 4'd0, 32'h0000_2000 + 32'(r), 5'd31));
      mq[1].push_back(mk(4'h2, 4'd0, 32'h0000_3000 + 32'(r), 5'd31));
    end
    gnt_log.delete();
    drain(200);
    chk("gnt_cnt", gnt_log.size(), 4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++) chk("gnt_order", gnt_log[i], exp_g[i]);

    // Single master 0, awlen=3, slave always ready, B one cycle after last beat.
    busy_cnt = 0; slog.delete(); slog_id.delete();
    t = mk(4'h3, 4'd3, 32'h0000_1000, 5'd31);
    mq[0].push_back(t);
    drain(100);
    chk("busy_cycles", busy_cnt, 7);
    chk("single_beats", slog.size(), 4);

    // Slave backpressure on all three channels.
    aw_stall = 3; w_toggle = 1; b_delay = 5;
    slog.delete(); slog_id.delete(); i0 = idle_ret;
    t = mk(4'h9, 4'd3, 32'hCAFE_0040, 5'd31);
    mq[2].push_back(t);
    drain(200);
    chk("bp_idle", idle_ret - i0, 1);
    chk("bp_beats", slog.size(), 4);
    for (int i = 0; i < slog.size(); i++) chk("bp_data", slog[i], beat_dat(t, i));
    w_toggle = 0; b_delay = 1;

    // Master 1 offers W before AW.
    w_early[1] = 1; early_held = 0; early_bad = 0;
    slog.delete(); slog_id.delete();
    t = mk(4'h5, 4'd2, 32'h0000_5500, 5'd31);
    mq[1].push_back(t);
    drain(100);
    chk("early_held", early_held != 0, 1'b1);
    chk("early_wready", early_bad, 0);
    chk("early_awid", cur_awid, t.id);
    chk("early_beats", slog.size(), 3);
    for (int i = 0; i < slog.size(); i++) begin
      chk("early_data", slog[i], beat_dat(t, i));
      chk("early_wid", slog_id[i], t.id);
    end
    w_early[1] = 0;

    // Reset while master 0 is mid-burst (pointer previously moved past master 1).
    mq[1].push_back(mk(4'h6, 4'd0, 32'h0000_6000, 5'd31));
    drain(100);
    mq[0].push_back(mk(4'h7, 4'd7, 32'h0000_7000, 5'd31));
    reached = 0;
    for (int n = 0; n < 100 && !reached; n++) begin
      tick();
      if (own == 0 && maw && mbeats == 2) reached = 1;
    end
    chk("mid_burst", reached, 1);
    drive();
    #1;
    reset = 1'b1;
    #1;
    check_quiet("midrst");
    clear_state();
    drive();
    @(negedge clk);
    reset = 1'b0;
    gnt_log.delete();
    mq[1].push_back(mk(4'hA, 4'd1, 32'h0000_A000, 5'd31));
    mq[2].push_back(mk(4'hB, 4'd1, 32'h0000_B000, 5'd31));
    drain(100);
    chk("post_rst_cnt", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("post_rst_gnt", gnt_log[0], 1);

`ifdef AXI_WARB_BEAT_CHECK_EN
    // Master raises wlast on the second beat of a four-beat burst.
    err_cnt = 0; slog.delete(); slog_id.delete(); d0 = done_cnt;
    t = mk(4'hC, 4'd3, 32'h0000_C000, 5'd1);
    mq[0].push_back(t);
    drain(100);
    chk("bc_err_pulses", err_cnt, 2);
    chk("bc_beats", slog.size(), 4);
    chk("bc_last_pos", last_pos, 3);
    chk("bc_done", done_cnt - d0, 1);
`endif

    // Randomised traffic on all masters with random slave/master readiness.
    rnd = 1; d0 = done_cnt; i0 = idle_ret;
    for (int k = 0; k < NM; k++) begin
      w_early[k] = 1'($urandom_range(0, 1));
      for (int j = 0; j < 6; j++)
        mq[k].push_back(mk(4'($urandom), 4'($urandom), $urandom, 5'd31));
    end
    drain(4000);
    chk("rnd_done", done_cnt - d0, 3 * 6);
    chk("rnd_idle", idle_ret - i0, 3 * 6);
    rnd = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
